osd_time_base_multi: RTL and testbench

Parametrised multi-channel time base for the OSD/PONG video pipeline. It generates NUM_CH independent one-cycle tick strobes and 50 % duty square outputs from `clk`, each with a run-time programmable divider. It also offers an optional per-channel cascade mode, for example frame counter → blink timer → animation step. It is the next generation of the two-output `osd_time_base` and feeds sprite animation, score blink and ball-speed logic.

---
 rtl/osd_pkg.sv | 18 +
 rtl/osd_tb_channel.sv | 64 ++++++
 rtl/osd_time_base_multi.sv | 83 ++++++++
 tb/tb_osd_time_base_multi.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : osd_pkg
// Description : Shared constants and helpers for the OSD time base.
// Revision    : 1.0 - initial release
// ============================================================================
package osd_pkg;

    localparam int c_CNT_W    = 16;
    localparam int c_DIV_INIT = 1;

    // Width of a channel-select field; never zero, even for a single channel.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/osd_tb_channel.sv
`default_nettype none
// ============================================================================
// Module      : osd_tb_channel
// Description : One time-base slice: reloading down-counter, tick and toggle.
// Revision    : 1.0 - initial release
// ============================================================================
module osd_tb_channel
    import osd_pkg::*;
#(
    parameter int CNT_W    = c_CNT_W,
    parameter int DIV_INIT = c_DIV_INIT
) (
    input  logic             clk,
    input  logic             start,
    input  logic             step,
    input  logic             sync,
    input  logic [CNT_W-1:0] div,
    output logic             tick,
    output logic             clk_out
);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_tick_q;
    logic             w_tick_d;
    logic             r_clk_out_q;
    logic             w_clk_out_d;

    // Sync outranks stepping; decrement only when non-zero, so no underflow.
    always_comb begin
        w_cnt_d     = r_cnt_q;
        w_tick_d    = 1'b0;
        w_clk_out_d = r_clk_out_q;
        if (sync) begin
            w_cnt_d     = div;
            w_clk_out_d = 1'b0;
        end else if (step) begin
            if (r_cnt_q == '0) begin
                w_cnt_d     = div;
                w_tick_d    = 1'b1;
                w_clk_out_d = ~r_clk_out_q;
            end else begin
                w_cnt_d = r_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            r_cnt_q     <= CNT_W'(DIV_INIT);
            r_tick_q    <= 1'b0;
            r_clk_out_q <= 1'b0;
        end else begin
            r_cnt_q     <= w_cnt_d;
            r_tick_q    <= w_tick_d;
            r_clk_out_q <= w_clk_out_d;
        end
    end

    assign tick    = r_tick_q;
    assign clk_out = r_clk_out_q;

endmodule
`default_nettype wire

// File: rtl/osd_time_base_multi.sv
`default_nettype none
// ============================================================================
// Module      : osd_time_base_multi
// Description : NUM_CH programmable tick/square time bases with cascade.
// Revision    : 1.0 - initial release
// ============================================================================
module osd_time_base_multi
    import osd_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = c_CNT_W,
    parameter int DIV_INIT = c_DIV_INIT
) (
    input  logic                      clk,
    input  logic                      start,
    input  logic                      enable,
    input  logic                      sync,
    input  logic                      div_we,
    input  logic [sel_w(NUM_CH)-1:0]  div_sel,
    input  logic [CNT_W-1:0]          div_val,
    input  logic                      div_casc,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         clk_out
);

    logic [CNT_W-1:0]  r_div_q  [NUM_CH];
    logic [CNT_W-1:0]  w_div_d  [NUM_CH];
    logic [CNT_W-1:0]  w_ch_div [NUM_CH];
    logic [NUM_CH-1:0] r_casc_q;
    logic [NUM_CH-1:0] w_casc_d;
    logic [NUM_CH-1:0] w_wr_hit;
    logic [NUM_CH-1:0] w_tick_lo;
    logic [NUM_CH-1:0] w_step;

    // Out-of-range selects match no channel, so such writes simply vanish.
    always_comb begin
        w_wr_hit  = '0;
        w_casc_d  = r_casc_q;
        w_tick_lo = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr_hit[i] = div_we && (int'(div_sel) == i);
            w_div_d[i]  = w_wr_hit[i] ? div_val : r_div_q[i];
            if (w_wr_hit[i]) begin
                w_casc_d[i] = (i != 0) && div_casc;
            end
            // A running reload keeps the old divider; only sync sees the new one.
            w_ch_div[i] = (sync && w_wr_hit[i]) ? div_val : r_div_q[i];
        end
        for (int i = 1; i < NUM_CH; i++) begin
            w_tick_lo[i] = tick[i-1];
        end
        w_step = {NUM_CH{enable}} & (~r_casc_q | w_tick_lo);
    end

    always_ff @(posedge clk) begin
        if (start) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div_q[i] <= CNT_W'(DIV_INIT);
            end
            r_casc_q <= '0;
        end else begin
            r_div_q  <= w_div_d;
            r_casc_q <= w_casc_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        osd_tb_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk     (clk),
            .start   (start),
            .step    (w_step[g]),
            .sync    (sync),
            .div     (w_ch_div[g]),
            .tick    (tick[g]),
            .clk_out (clk_out[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_osd_time_base_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_osd_time_base_multi
// Description : Scoreboard bench for a 4-channel and a 3-channel time base.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_time_base_multi;

    localparam int c_DIV_INIT = 1;

    logic        clk = 1'b0;
    logic        start = 1'b1;
    logic        enable = 1'b0;
    logic        sync = 1'b0;
    logic        div_we = 1'b0;
    logic [1:0]  div_sel = '0;
    logic [15:0] div_val = '0;
    logic        div_casc = 1'b0;
    logic [3:0]  tick4, clk4;
    logic [2:0]  tick3, clk3;

    always #5 clk = ~clk;

    osd_time_base_multi #(.NUM_CH(4), .CNT_W(16), .DIV_INIT(c_DIV_INIT)) dut4 (
        .clk(clk), .start(start), .enable(enable), .sync(sync),
        .div_we(div_we), .div_sel(div_sel), .div_val(div_val), .div_casc(div_casc),
        .tick(tick4), .clk_out(clk4)
    );

    osd_time_base_multi #(.NUM_CH(3), .CNT_W(16), .DIV_INIT(c_DIV_INIT)) dut3 (
        .clk(clk), .start(start), .enable(enable), .sync(sync),
        .div_we(div_we), .div_sel(div_sel), .div_val(div_val), .div_casc(div_casc),
        .tick(tick3), .clk_out(clk3)
    );

    // Reference state: index 0 models the 4-channel DUT, index 1 the 3-channel one.
    int   m_div  [2][4];
    int   m_cnt  [2][4];
    bit   m_casc [2][4];
    bit   m_tick [2][4];
    bit   m_clk  [2][4];

    logic [7:0] q4[$];
    logic [7:0] q3[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;
    bit   running = 1'b1;

    function automatic logic [7:0] model_step(int d, int n, bit st, bit en, bit sy,
                                              bit we, int sel, int val, bit cs);
        bit         old_tick[4];
        int         new_div[4];
        bit         new_casc[4];
        bit         stepping;
        logic [7:0] e = '0;
        for (int ch = 0; ch < 4; ch++) old_tick[ch] = m_tick[d][ch];
        for (int ch = 0; ch < n; ch++) begin
            if (st) begin
                m_div[d][ch] = c_DIV_INIT; m_cnt[d][ch] = c_DIV_INIT;
                m_casc[d][ch] = 0; m_tick[d][ch] = 0; m_clk[d][ch] = 0;
                continue;
            end
            new_div[ch]  = m_div[d][ch];
            new_casc[ch] = m_casc[d][ch];
            if (we && sel == ch) begin
                new_div[ch]  = val;
                new_casc[ch] = (ch != 0) && cs;
            end
            if (sy) begin
                m_cnt[d][ch] = new_div[ch]; m_tick[d][ch] = 0; m_clk[d][ch] = 0;
            end else begin
                stepping = en && (ch == 0 || !m_casc[d][ch] || old_tick[ch-1]);
                m_tick[d][ch] = 0;
                if (stepping) begin
                    if (m_cnt[d][ch] == 0) begin
                        m_cnt[d][ch] = m_div[d][ch];
                        m_tick[d][ch] = 1;
                        m_clk[d][ch] = !m_clk[d][ch];
                    end else begin
                        m_cnt[d][ch] = m_cnt[d][ch] - 1;
                    end
                end
            end
            m_div[d][ch]  = new_div[ch];
            m_casc[d][ch] = new_casc[ch];
        end
        for (int ch = 0; ch < n; ch++) begin
            e[n+ch] = m_tick[d][ch];
            e[ch]   = m_clk[d][ch];
        end
        return e;
    endfunction

    task automatic cyc(bit st, bit en, bit sy, bit we, int sel, int val, bit cs);
        start = st; enable = en; sync = sy; div_we = we;
        div_sel = 2'(sel); div_val = 16'(val); div_casc = cs;
        q4.push_back(model_step(0, 4, st, en, sy, we, sel, val, cs));
        q3.push_back(model_step(1, 3, st, en, sy, we, sel, val, cs));
        @(negedge clk);
    endtask

    task automatic idle(int n, bit en);
        for (int i = 0; i < n; i++) cyc(0, en, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every edge the DUTs present a new registered output.
    initial begin : monitor
        logic [7:0] exp_v, act_v;
        while (running) begin
            @(posedge clk);
            #1;
            if (!running) break;
            cyc_no++;
            if (q4.size() == 0 || q3.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL scoreboard_empty cyc=%0d actual=empty required=entry", cyc_no);
                continue;
            end
            exp_v = q4.pop_front();
            act_v = {tick4, clk4};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL ch4_outputs cyc=%0d actual=%b required=%b", cyc_no, act_v, exp_v);
            end
            exp_v = q3.pop_front();
            act_v = {2'b00, tick3, clk3};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL ch3_outputs cyc=%0d actual=%b required=%b", cyc_no, act_v, exp_v);
            end
        end
    end

    initial begin : stimulus
        int r;
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        idle(12, 1);                         // reset release, ticks on edges 2,4,6
        cyc(0, 1, 0, 1, 2, 4, 0);            // ch2 div=4 mid-count
        idle(25, 1);
        cyc(0, 1, 0, 1, 0, 0, 0);            // ch0 div=0
        idle(8, 1);
        cyc(0, 1, 0, 1, 0, 2, 0);            // cascade: ch0 div=2, ch1 div=1 casc
        cyc(0, 1, 0, 1, 1, 1, 1);
        idle(30, 1);
        idle(7, 0);                          // enable gap
        cyc(0, 0, 1, 1, 3, 9, 0);            // sync together with ch3 div=9
        idle(25, 1);
        cyc(0, 1, 0, 1, 3, 7, 0);            // out-of-range select for the 3-ch DUT
        idle(20, 1);
        cyc(1, 1, 0, 1, 1, 5, 1);            // reset during a write
        idle(10, 1);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            cyc(r < 4, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 3),
                $urandom_range(0, 6), $urandom_range(0, 1) == 1);
        end
        running = 1'b0;
        @(posedge clk);
        #2;
        n_tests++;
        if (q4.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q4.size() + q3.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
